// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the mesh router input stage.
//   - one-hot output direction codes {UP, DOWN, LEFT, RIGHT, PE} = bits [4:0]
//   - default flit field positions for dest_x / dest_y
//   - xy_route(): dimension-ordered (X first, then Y) route computation
package router_pkg;

  typedef logic [4:0] dir_t;

  localparam dir_t DIR_UP    = 5'b10000;
  localparam dir_t DIR_DOWN  = 5'b01000;
  localparam dir_t DIR_LEFT  = 5'b00100;
  localparam dir_t DIR_RIGHT = 5'b00010;
  localparam dir_t DIR_PE    = 5'b00001;
  localparam dir_t DIR_NONE  = 5'b00000;

  localparam int DX_LSB_DEF = 0;
  localparam int DY_LSB_DEF = 2;

  // Coordinates are zero-extended to 32 bits by the caller so the
  // comparison is unsigned regardless of X_W / Y_W.
  function automatic dir_t xy_route(input logic [31:0] dx, input logic [31:0] dy,
                                    input logic [31:0] my_x, input logic [31:0] my_y);
    if (dx > my_x)      return DIR_RIGHT;
    else if (dx < my_x) return DIR_LEFT;
    else if (dy > my_y) return DIR_UP;
    else if (dy < my_y) return DIR_DOWN;
    else                return DIR_PE;
  endfunction

endpackage

// File: rtl/router_input_port_if.sv
// router_input_port_if: handshake bundle between an input port, its
// upstream link and the output arbiters / crossbar.
//   in_valid/in_flit : upstream -> port     in_ready : port -> upstream
//   req/out_flit     : port -> arbiters/xbar gnt     : arbiters -> port
//   count            : port FIFO occupancy
// Modports: master = environment side (upstream + arbiters), slave = port.
interface router_input_port_if #(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] in_flit;
  logic [4:0]        req;
  logic              gnt;
  logic [FLIT_W-1:0] out_flit;
  logic [CNT_W-1:0]  count;

  modport master (output in_valid, in_flit, gnt,
                  input  in_ready, req, out_flit, count);
  modport slave  (input  in_valid, in_flit, gnt,
                  output in_ready, req, out_flit, count);
endinterface

// File: rtl/router_flit_fifo.sv
// router_flit_fifo: synchronous FIFO, asynchronous active-high reset.
// Ports:
//   clk, reset          clock / async reset
//   wr_en_i, wr_data_i  push (ignored when full)
//   rd_en_i             pop  (ignored when empty)
//   head_o              data at read pointer (RAM head, valid when !empty_o)
//   count_o             occupancy 0..DEPTH
//   full_o, empty_o     status
module router_flit_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_ok   = wr_en_i & ~full_o;
  assign rd_ok   = rd_en_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers are log2(DEPTH) bits, so DEPTH-1 -> 0 wraps for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every consumer.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/router_input_port.sv
// router_input_port: one NoC router input port. Buffers single-flit packets,
// XY-routes the head flit and holds a one-hot request until granted.
// Ports:
//   clk, reset   clock / async active-high reset
//   port_if      router_input_port_if.slave (in_valid/in_ready/in_flit,
//                req/gnt/out_flit, count)
// Build option: ROUTER_IN_ROUTE_REG_EN registers the route; req then arrives
// one cycle later and each pop is followed by a one-cycle req=0 bubble.
module router_input_port
  import router_pkg::*;
#(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 4,
  parameter int X_W    = 2,
  parameter int Y_W    = 2,
  parameter int MY_X   = 0,
  parameter int MY_Y   = 0,
  parameter int DX_LSB = DX_LSB_DEF,
  parameter int DY_LSB = DY_LSB_DEF
) (
  input logic               clk,
  input logic               reset,
  router_input_port_if.slave port_if
);
  logic [FLIT_W-1:0]        head;
  logic [$clog2(DEPTH):0]   cnt;
  logic                     full, empty;
  logic                     wr_en, rd_en;
  dir_t                     route_head;
  dir_t                     req;

  assign wr_en = port_if.in_valid & ~full;
  // gnt only counts while a request is actually up.
  assign rd_en = port_if.gnt & (req != DIR_NONE);

  router_flit_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_data_i (port_if.in_flit),
    .rd_en_i   (rd_en),
    .head_o    (head),
    .count_o   (cnt),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign route_head = xy_route(32'(head[DX_LSB +: X_W]), 32'(head[DY_LSB +: Y_W]),
                               32'(MY_X), 32'(MY_Y));

`ifdef ROUTER_IN_ROUTE_REG_EN
  dir_t req_q, req_d;

  // Load when a head is present but not yet latched; clear on every pop.
  // The clear forces a one-cycle bubble before the next head's route shows.
  always_comb begin
    req_d = req_q;
    if (rd_en)                             req_d = DIR_NONE;
    else if (!empty && req_q == DIR_NONE)  req_d = route_head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_q <= DIR_NONE;
    else       req_q <= req_d;
  end

  assign req = req_q;
`else
  // Head is stable until popped (in-order FIFO), so req holds naturally.
  assign req = empty ? DIR_NONE : route_head;
`endif

  assign port_if.req      = req;
  assign port_if.out_flit = head;
  assign port_if.count    = cnt;
  assign port_if.in_ready = ~full;
endmodule

// File: tb/tb_router_input_port.sv
module tb_router_input_port;
  localparam int FW    = 16;
  localparam int DEPTH = 4;
  localparam int MY_X  = 1;
  localparam int MY_Y  = 1;
`ifdef ROUTER_IN_ROUTE_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  router_input_port_if #(.FLIT_W(FW), .DEPTH(DEPTH)) bus();

  router_input_port #(
    .FLIT_W(FW), .DEPTH(DEPTH), .X_W(2), .Y_W(2),
    .MY_X(MY_X), .MY_Y(MY_Y), .DX_LSB(0), .DY_LSB(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .port_if (bus.slave)
  );

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [4:0]    req;
    logic [FW-1:0] flit;
  } exp_t;

  exp_t          exp_q[$];   // scoreboard: expected pops in order
  logic [FW-1:0] mq[$];      // reference FIFO contents
  int            age;        // cycles the current model head has been head
  logic [4:0]    smp_req;
  logic [FW-1:0] smp_flit;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // XY routing straight from the rules: X first, then Y, else local.
  function automatic logic [4:0] ref_route(input logic [FW-1:0] f);
    int dx, dy;
    dx = {30'b0, f[1:0]};
    dy = {30'b0, f[3:2]};
    if (dx > MY_X) return 5'b00010;
    if (dx < MY_X) return 5'b00100;
    if (dy > MY_Y) return 5'b10000;
    if (dy < MY_Y) return 5'b01000;
    return 5'b00001;
  endfunction

  function automatic logic [FW-1:0] mkflit(input int dx, input int dy);
    logic [FW-1:0] f;
    f = FW'($urandom);
    f[1:0] = 2'(dx);
    f[3:2] = 2'(dy);
    return f;
  endfunction

  // Cycle checker: sample DUT mid-cycle against the reference model.
  always @(negedge clk) begin
    if (reset) begin
      smp_req  <= '0;
      smp_flit <= '0;
    end else begin : chk_blk
      bit vis;
      smp_req  <= bus.req;
      smp_flit <= bus.out_flit;
      vis = (mq.size() > 0) && (age >= LAT);
      chk("count", 64'(bus.count), 64'(mq.size()));
      chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
      chk("req_present", 64'(bus.req != 0), 64'(vis));
      if (vis) begin
        chk("req_route", 64'(bus.req), 64'(ref_route(mq[0])));
        chk("out_flit", 64'(bus.out_flit), 64'(mq[0]));
      end
    end
  end

  // Monitor (pops scoreboard on DUT pop) and model update, per edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      exp_q.delete();
      age = 0;
    end else begin : mdl
      bit pop, push, was_empty;
      exp_t e;
      if (bus.gnt && smp_req != 0) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 64'(smp_req), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("sb_req", 64'(smp_req), 64'(e.req));
          chk("sb_flit", 64'(smp_flit), 64'(e.flit));
        end
      end
      pop       = bus.gnt && (mq.size() > 0) && (age >= LAT);
      push      = bus.in_valid && (mq.size() < DEPTH);
      was_empty = (mq.size() == 0);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(bus.in_flit);
        exp_q.push_back('{ref_route(bus.in_flit), bus.in_flit});
      end
      if (pop || (push && was_empty)) age = 0;
      else age++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [FW-1:0] f);
    bus.in_valid = 1'b1;
    bus.in_flit  = f;
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.gnt = 1'b1;
    for (int i = 0; i < 30 && mq.size() > 0; i++) cyc();
    chk("drain_timeout", 64'(mq.size()), 64'(0));
    bus.gnt = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int         dxs[5];
    int         dys[5];
    logic [4:0] exp_r[5];
    dxs   = '{2, 0, 1, 1, 1};
    dys   = '{1, 1, 2, 0, 1};
    exp_r = '{5'b00010, 5'b00100, 5'b10000, 5'b01000, 5'b00001};

    bus.in_valid = 1'b0;
    bus.in_flit  = '0;
    bus.gnt      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_count", 64'(bus.count), 64'(0));
    chk("rst_req", 64'(bus.req), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Routing table, one flit at a time.
    for (int i = 0; i < 5; i++) begin
      push1(mkflit(dxs[i], dys[i]));
      repeat (LAT) cyc();
      chk("route_tbl", 64'(bus.req), 64'(exp_r[i]));
      drain();
    end

    // Fill to DEPTH with no grant, then drain back-to-back.
    bus.in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_flit = mkflit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    chk("full_count", 64'(bus.count), 64'(DEPTH));
    bus.gnt = 1'b1;
    cyc();
    chk("after_pop_in_ready", 64'(bus.in_ready), 64'(1));
    drain();

    // Simultaneous push and pop with two buffered.
    push1(mkflit(2, 0));
    push1(mkflit(0, 3));
    bus.in_valid = 1'b1;
    bus.gnt      = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_flit = mkflit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cyc();
    end
    bus.in_valid = 1'b0;
    drain();

    // Spurious grant on empty FIFO.
    bus.gnt = 1'b1;
    repeat (3) cyc();
    chk("spurious_count", 64'(bus.count), 64'(0));
    bus.gnt = 1'b0;
    push1(mkflit(1, 2));
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_flit  = FW'($urandom);
      bus.gnt      = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset mid-traffic with three buffered.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_flit = mkflit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_count", 64'(bus.count), 64'(3));
    reset = 1'b1;
    #1;
    chk("midrst_count", 64'(bus.count), 64'(0));
    chk("midrst_req", 64'(bus.req), 64'(0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    cyc();
    reset   = 1'b0;
    bus.gnt = 1'b1;
    repeat (2) cyc();
    chk("post_rst_count", 64'(bus.count), 64'(0));
    bus.gnt = 1'b0;
    push1(mkflit(0, 0));
    drain();

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
